// File: rtl/finger_input_conditioner.sv
// finger_input_conditioner
// Synchronises and debounces four raw finger switches. A nonzero debounced
// pattern that stays unchanged for HOLD_CYCLES cycles is committed to
// {a_q,b_q,c_q,d_q}, and commit pulses once. After a commit, all fingers
// must be released before the next commit can happen.
module finger_input_conditioner #(
    parameter int unsigned DB_CYCLES   = 50000,
    parameter int unsigned HOLD_CYCLES = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       a_q,
    output logic       b_q,
    output logic       c_q,
    output logic       d_q,
    output logic [3:0] stable,
    output logic       commit,
    output logic       busy
);

    localparam int unsigned DW = $clog2(DB_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        COMMIT,
        WAIT_REL
    } state_t;

    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    sync2_q, sync2_d;
    logic [3:0]    cand_q, cand_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [3:0]    stable_q, stable_d;
    logic [3:0]    stable_prev_q, stable_prev_d;
    state_t        state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [3:0]    pat_q, pat_d;

    // Two-flop synchroniser on the raw switch vector {a,b,c,d}
    always_comb begin
        sync1_d = {a, b, c, d};
        sync2_d = sync1_q;
    end

    // Debounce: the candidate must match the synchronised input for
    // DB_CYCLES consecutive compares before it becomes the stable value
    always_comb begin
        cand_d        = cand_q;
        dcnt_d        = dcnt_q;
        stable_d      = stable_q;
        stable_prev_d = stable_q;
        if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            dcnt_d = '0;
        end else if (dcnt_q != DB_LAST) begin
            dcnt_d = dcnt_q + DW'(1);
        end else begin
            stable_d = cand_q;
        end
    end

    // Hold/commit FSM: next state, hold counter, committed pattern, Moore outputs
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        pat_d   = pat_q;
        commit  = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (stable_q != '0) begin
                    state_d = HOLD;
                    hcnt_d  = '0;
                end
            end
            HOLD: begin
                // stable_prev_q lags stable_q by one cycle, so a mismatch means
                // the debounced pattern changed on the previous edge
                if (stable_q == '0) begin
                    state_d = IDLE;
                end else if (stable_q != stable_prev_q) begin
                    hcnt_d = '0;
                end else if (hcnt_q == HOLD_LAST) begin
                    state_d = COMMIT;
                    pat_d   = stable_q;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            COMMIT: begin
                commit  = 1'b1;
                state_d = WAIT_REL;
            end
            WAIT_REL: begin
                if (stable_q == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            cand_q        <= '0;
            dcnt_q        <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            state_q       <= IDLE;
            hcnt_q        <= '0;
            pat_q         <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cand_q        <= cand_d;
            dcnt_q        <= dcnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            state_q       <= state_d;
            hcnt_q        <= hcnt_d;
            pat_q         <= pat_d;
        end
    end

    assign stable                 = stable_q;
    assign {a_q, b_q, c_q, d_q}   = pat_q;

endmodule

// File: tb/tb_finger_input_conditioner.sv
// Directed bench for finger_input_conditioner with DB_CYCLES=4, HOLD_CYCLES=8.
// Debounced value lands 7 edges after a raw change; commit is high in the
// cycle after edge 16 counted from the raw change.
module tb_finger_input_conditioner;

    logic       clk;
    logic       reset;
    logic       a, b, c, d;
    logic       a_q, b_q, c_q, d_q;
    logic [3:0] stable;
    logic       commit;
    logic       busy;

    int unsigned passed;
    int unsigned total;
    int unsigned commit_cnt;
    int unsigned base;

    finger_input_conditioner #(
        .DB_CYCLES  (4),
        .HOLD_CYCLES(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .a_q   (a_q),
        .b_q   (b_q),
        .c_q   (c_q),
        .d_q   (d_q),
        .stable(stable),
        .commit(commit),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count commit pulses away from the rising edge
    initial commit_cnt = 0;
    always @(negedge clk) begin
        if (commit === 1'b1) commit_cnt = commit_cnt + 1;
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_raw(input logic [3:0] v);
        {a, b, c, d} = v;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        reset  = 1'b1;
        set_raw(4'b0000);
        tick(2);

        // Reset state
        check("rst_stable", 32'(stable), 32'h0);
        check("rst_pat", 32'({a_q, b_q, c_q, d_q}), 32'h0);
        check("rst_commit", 32'(commit), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);

        // Clean press of 1100
        base  = commit_cnt;
        reset = 1'b0;
        set_raw(4'b1100);
        tick(6);
        check("press_stable_e6", 32'(stable), 32'h0);
        tick(1);
        check("press_stable_e7", 32'(stable), 32'hC);
        check("press_busy_e7", 32'(busy), 32'h0);
        tick(1);
        check("press_busy_e8", 32'(busy), 32'h1);
        tick(7);
        check("press_commit_e15", 32'(commit), 32'h0);
        tick(1);
        check("press_commit_e16", 32'(commit), 32'h1);
        check("press_pat_e16", 32'({a_q, b_q, c_q, d_q}), 32'hC);
        tick(1);
        check("press_commit_e17", 32'(commit), 32'h0);
        check("press_busy_e17", 32'(busy), 32'h1);
        set_raw(4'b0000);
        tick(8);
        check("press_release_busy", 32'(busy), 32'h0);
        check("press_pat_held", 32'({a_q, b_q, c_q, d_q}), 32'hC);
        check("press_commit_count", commit_cnt - base, 32'd1);

        // Glitch shorter than the debounce window
        base = commit_cnt;
        set_raw(4'b0010);
        tick(3);
        set_raw(4'b0000);
        begin
            logic seen;
            seen = 1'b0;
            for (int i = 0; i < 12; i++) begin
                tick(1);
                if (stable !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
            end
            check("glitch_quiet", 32'(seen), 32'h0);
        end
        check("glitch_commit_count", commit_cnt - base, 32'd0);

        // Pattern change during HOLD restarts the hold count
        base = commit_cnt;
        set_raw(4'b1000);
        tick(8);
        check("chg_busy_e8", 32'(busy), 32'h1);
        check("chg_stable_e8", 32'(stable), 32'h8);
        set_raw(4'b1010);
        tick(7);
        check("chg_stable_e15", 32'(stable), 32'hA);
        tick(1);
        check("chg_no_commit_e16", 32'(commit), 32'h0);
        tick(7);
        check("chg_commit_e23", 32'(commit), 32'h0);
        tick(1);
        check("chg_commit_e24", 32'(commit), 32'h1);
        check("chg_pat", 32'({a_q, b_q, c_q, d_q}), 32'hA);
        set_raw(4'b0000);
        tick(8);
        check("chg_release_busy", 32'(busy), 32'h0);
        check("chg_commit_count", commit_cnt - base, 32'd1);

        // Change without release gives no second commit
        base = commit_cnt;
        set_raw(4'b0001);
        tick(16);
        check("hc_commit1", 32'(commit), 32'h1);
        check("hc_pat1", 32'({a_q, b_q, c_q, d_q}), 32'h1);
        set_raw(4'b0011);
        tick(20);
        check("hc_stable_changed", 32'(stable), 32'h3);
        check("hc_busy_wait", 32'(busy), 32'h1);
        check("hc_pat_held", 32'({a_q, b_q, c_q, d_q}), 32'h1);
        check("hc_count_one", commit_cnt - base, 32'd1);
        set_raw(4'b0000);
        tick(8);
        check("hc_release_busy", 32'(busy), 32'h0);
        set_raw(4'b0011);
        tick(16);
        check("hc_commit2", 32'(commit), 32'h1);
        check("hc_pat2", 32'({a_q, b_q, c_q, d_q}), 32'h3);
        set_raw(4'b0000);
        tick(8);
        check("hc_count_two", commit_cnt - base, 32'd2);

        // Reset in the middle of HOLD aborts; re-qualification from scratch
        base = commit_cnt;
        set_raw(4'b1111);
        tick(12);
        check("rh_busy_before", 32'(busy), 32'h1);
        reset = 1'b1;
        tick(1);
        check("rh_busy", 32'(busy), 32'h0);
        check("rh_stable", 32'(stable), 32'h0);
        check("rh_pat", 32'({a_q, b_q, c_q, d_q}), 32'h0);
        check("rh_commit", 32'(commit), 32'h0);
        reset = 1'b0;
        tick(6);
        check("rh_stable_e6", 32'(stable), 32'h0);
        tick(1);
        check("rh_stable_e7", 32'(stable), 32'hF);
        tick(8);
        check("rh_commit_e15", 32'(commit), 32'h0);
        check("rh_count_none", commit_cnt - base, 32'd0);
        tick(1);
        check("rh_commit_e16", 32'(commit), 32'h1);
        check("rh_pat_new", 32'({a_q, b_q, c_q, d_q}), 32'hF);
        set_raw(4'b0000);
        tick(8);
        check("rh_count_one", commit_cnt - base, 32'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/finger_input_conditioner.md
FINGER_INPUT_CONDITIONER -- requirements
Module: finger_input_conditioner

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 50000, debounce qualification length in clk cycles; legal range ≥2.
REQ-002 SHALL have parameter HOLD_CYCLES, default 25000000, number of cycles a nonzero debounced pattern must be held before commit; legal range ≥1.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have ports a, b, c, d, input, 1 each, raw asynchronous finger switches.
REQ-006 SHALL have ports a_q, b_q, c_q, d_q, output, 1 each, last committed pattern; feeds the finger decoder.
REQ-007 SHALL have port stable, output, 4, debounced pattern {a,b,c,d}.
REQ-008 SHALL have port commit, output, 1, one-cycle pulse marking a new committed pattern for the accumulator.
REQ-009 SHALL have port busy, output, 1, high when FSM is not in IDLE.

Function
REQ-010 SHALL pass each raw input through a 2-flop synchronizer; sync vector s2 = {a,b,c,d} after the second flop.
REQ-011 SHALL hold candidate register cand[3:0] and counter dcnt, width ceil(log2(DB_CYCLES)).
REQ-012 SHALL, when s2 != cand, load cand <= s2 and dcnt <= 0.
REQ-013 SHALL, when s2 == cand and dcnt != DB_CYCLES-1, increment dcnt; dcnt saturates at DB_CYCLES-1, with no wrap-around.
REQ-014 SHALL, when s2 == cand and dcnt == DB_CYCLES-1, load stable <= cand.
REQ-015 SHALL give a raw transition held constant a latency of exactly DB_CYCLES+3 rising edges to appear on stable.
REQ-016 SHALL ignore any raw pulse shorter than DB_CYCLES cycles, leaving stable unchanged.
REQ-017 SHALL implement FSM states IDLE, HOLD, COMMIT, WAIT_REL with hold counter hcnt, width ceil(log2(HOLD_CYCLES+1)).
REQ-018 SHALL, in IDLE, transition to HOLD with hcnt <= 0 when stable != 0, and otherwise remain in IDLE.
REQ-019 SHALL, in HOLD, go to IDLE when stable == 0, which takes priority over all other HOLD transitions.
REQ-020 SHALL, in HOLD, set hcnt <= 0 and stay in HOLD when stable changed to a different nonzero value in the previous cycle.
REQ-021 SHALL, in HOLD with stable unchanged, go to COMMIT and load {a_q,b_q,c_q,d_q} <= stable when hcnt == HOLD_CYCLES-1, and otherwise increment hcnt.
REQ-022 SHALL, in COMMIT, assert commit=1 for exactly one cycle, then go to WAIT_REL unconditionally.
REQ-023 SHALL, in WAIT_REL, go to IDLE when stable == 0; pattern changes in WAIT_REL SHALL NOT produce a commit.
REQ-024 SHALL drive commit only in COMMIT state as a Moore output, with no back-to-back commit pulses possible.
REQ-025 SHALL give a nonzero pattern whose stable update occurs at edge E a commit that is high in the cycle following edge E+HOLD_CYCLES+1.
REQ-026 SHALL hold a_q..d_q between commits, changing only on the HOLD->COMMIT edge.
REQ-027 SHALL set busy = (state != IDLE).

Reset
REQ-028 SHALL, with reset high at a rising edge, clear the synchronizer flops, cand, dcnt, stable, hcnt, a_q..d_q and commit to 0, and set state to IDLE.
REQ-029 SHALL, on reset during HOLD or COMMIT, abort the operation: no commit pulse on or after the reset edge, and a_q..d_q = 0 from the next cycle.
REQ-030 SHALL, after reset deasserts, require full DB_CYCLES+3 qualification again even if raw inputs are unchanged.

Verification (DB_CYCLES=4, HOLD_CYCLES=8)
REQ-031 Bench SHALL cover clean press: raw 4'b1100 from cycle 0, held -> stable=4'b1100 after edge 7; commit high exactly one cycle after edge 16; a_q..d_q=1,1,0,0.
REQ-032 Bench SHALL cover glitch: raw 4'b0010 for 3 cycles, then 0 -> stable stays 0, busy stays 0, no commit.
REQ-033 Bench SHALL cover pattern change in HOLD: 4'b1000 stable, then 4'b1010 before hcnt reaches 7 -> hcnt restarts; single commit with a_q..d_q=1,0,1,0.
REQ-034 Bench SHALL cover hold-then-change: after commit of 4'b0001, raw switches to 4'b0011 without release -> no second commit; release to 0 then press 4'b0011 -> second commit with a_q..d_q=0,0,1,1.
REQ-035 Bench SHALL cover reset mid-HOLD: reset pulse 1 cycle during HOLD -> state IDLE, all outputs 0, no commit; re-press 4'b1111 commits normally after full latency.
